// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state encoding and digit-validity helper for the
// serial BCD subtractor and its digit slice.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_RADIX   = 10;

    // S_NEGATE is only reachable when BCD_SUB_SIGN_MAGNITUDE_EN is defined.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_NEGATE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] n);
        return n <= BCD_DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_subtractor.sv
// One BCD digit of subtraction with borrow: d = x - y - bin, corrected by
// +10 when the raw result goes negative.
module bcd_digit_subtractor
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] x,
    input  logic [BCD_DIGIT_W-1:0] y,
    input  logic                   bin,
    output logic [BCD_DIGIT_W-1:0] d,
    output logic                   bout
);

    logic [BCD_DIGIT_W:0] t;

    // Range is -10..9, so bit 4 of the two's-complement result is the sign.
    assign t    = {1'b0, x} - {1'b0, y} - {{BCD_DIGIT_W{1'b0}}, bin};
    assign bout = t[BCD_DIGIT_W];
    assign d    = bout ? t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_RADIX)
                       : t[BCD_DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial multi-digit BCD subtractor (diff = a - b), LSB digit first.
// Define BCD_SUB_SIGN_MAGNITUDE_EN to output |a - b| instead of ten's complement.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    output logic                          ready,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] diff,
    output logic                          borrow_out,
    output logic                          invalid
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     diff_q, diff_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic             invalid_q, invalid_d;
    logic             done_q, done_d;

    logic                   any_bad;
    logic [BCD_DIGIT_W-1:0] sub_x, sub_y, sub_d;
    logic                   sub_bout;

    // The done pulse trails the DONE state by one cycle, so ready stays low
    // until the cycle after done.
    assign ready      = (state_q == S_IDLE) && !done_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign invalid    = invalid_q;

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                !is_bcd_digit(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
                any_bad = 1'b1;
        end
    end

    // A single digit slice serves both RUN (a_i - b_i) and NEGATE (0 - diff_i).
    always_comb begin
        sub_x = a_q[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W];
        sub_y = b_q[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W];
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
        if (state_q == S_NEGATE) begin
            sub_x = '0;
            sub_y = diff_q[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W];
        end
`endif
    end

    bcd_digit_subtractor u_digit (
        .x    (sub_x),
        .y    (sub_y),
        .bin  (borrow_q),
        .d    (sub_d),
        .bout (sub_bout)
    );

    // NOTE: every next-state signal is defaulted to its register first, so no
    // path through the case below can infer a latch.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        diff_d       = diff_q;
        idx_d        = idx_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        invalid_d    = invalid_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && ready) begin
                    a_d          = a;
                    b_d          = b;
                    diff_d       = '0;
                    idx_d        = '0;
                    borrow_d     = 1'b0;
                    borrow_out_d = 1'b0;
                    invalid_d    = any_bad;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                diff_d[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W] = invalid_q ? '0 : sub_d;
                borrow_d = sub_bout;
                if (idx_q == LAST_IDX) begin
                    borrow_out_d = sub_bout && !invalid_q;
                    idx_d        = '0;
                    borrow_d     = 1'b0;
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
                    state_d      = (sub_bout && !invalid_q) ? S_NEGATE : S_DONE;
`else
                    state_d      = S_DONE;
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
            S_NEGATE: begin
                diff_d[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W] = sub_d;
                borrow_d = sub_bout;
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
`endif
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            diff_q       <= '0;
            idx_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            invalid_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            diff_q       <= diff_d;
            idx_q        <= idx_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            invalid_q    <= invalid_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed, table-driven bench for bcd_serial_subtractor (DIGITS=4), with
// hand-written sequences for start-while-busy and reset-mid-operation.
module tb_bcd_serial_subtractor;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int L_POS  = DIGITS + 1;
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
    localparam int L_NEG  = 2 * DIGITS + 1;
`else
    localparam int L_NEG  = DIGITS + 1;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, done, borrow_out, invalid;
    logic [W-1:0] diff;

    int checks = 0;
    int errors = 0;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .invalid    (invalid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         inv;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for ready, issues one start, then counts edges after the accept
    // edge until done is seen (bounded) plus two trailing cycles.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         output int lat, output int pulses);
        int guard;
        guard = 0;
        while (!ready && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_before_start", 32'(ready), 32'd1);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 0;
        pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) begin
                pulses++;
                if (lat == 0) lat = n;
            end
            if (lat != 0 && n >= lat + 2) break;
        end
    endtask

    initial begin
        int lat, pulses;

        vecs[0] = '{a: 16'h5000, b: 16'h1234, d: 16'h3766, bo: 1'b0, inv: 1'b0, lat: L_POS};
        vecs[1] = '{a: 16'h0100, b: 16'h0001, d: 16'h0099, bo: 1'b0, inv: 1'b0, lat: L_POS};
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
        vecs[2] = '{a: 16'h0012, b: 16'h0345, d: 16'h0333, bo: 1'b1, inv: 1'b0, lat: L_NEG};
        vecs[3] = '{a: 16'h0000, b: 16'h0001, d: 16'h0001, bo: 1'b1, inv: 1'b0, lat: L_NEG};
`else
        vecs[2] = '{a: 16'h0012, b: 16'h0345, d: 16'h9667, bo: 1'b1, inv: 1'b0, lat: L_NEG};
        vecs[3] = '{a: 16'h0000, b: 16'h0001, d: 16'h9999, bo: 1'b1, inv: 1'b0, lat: L_NEG};
`endif
        vecs[4] = '{a: 16'h00A0, b: 16'h0001, d: 16'h0000, bo: 1'b0, inv: 1'b1, lat: L_POS};
        vecs[5] = '{a: 16'h9999, b: 16'h9999, d: 16'h0000, bo: 1'b0, inv: 1'b0, lat: L_POS};
        vecs[6] = '{a: 16'h1234, b: 16'h0000, d: 16'h1234, bo: 1'b0, inv: 1'b0, lat: L_POS};
        vecs[7] = '{a: 16'h1000, b: 16'h0999, d: 16'h0001, bo: 1'b0, inv: 1'b0, lat: L_POS};
        vecs[8] = '{a: 16'h0000, b: 16'h9A00, d: 16'h0000, bo: 1'b0, inv: 1'b1, lat: L_POS};
        vecs[9] = '{a: 16'h0000, b: 16'h0000, d: 16'h0000, bo: 1'b0, inv: 1'b0, lat: L_POS};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat, pulses);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_pulses", i), 32'(pulses), 32'd1);
            check($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].d));
            check($sformatf("v%0d_borrow", i), 32'(borrow_out), 32'(vecs[i].bo));
            check($sformatf("v%0d_invalid", i), 32'(invalid), 32'(vecs[i].inv));
        end

        // Start pulsed while RUN is busy must be ignored.
        begin
            int guard;
            guard = 0;
            while (!ready && guard < 50) begin
                tick();
                guard++;
            end
            a = 16'h5000; b = 16'h1234; start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            a = 16'h9999; b = 16'h0000; start = 1'b1;
            tick();
            start = 1'b0;
            pulses = 0;
            for (int n = 0; n < 12; n++) begin
                tick();
                if (done) pulses++;
            end
            check("busy_start_pulses", 32'(pulses), 32'd1);
            check("busy_start_diff", 32'(diff), 32'h3766);
            check("busy_start_borrow", 32'(borrow_out), 32'd0);
        end

        // Reset while digit 2 is being processed abandons the operation.
        begin
            a = 16'h5000; b = 16'h1234; start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("midrst_ready", 32'(ready), 32'd1);
            check("midrst_diff", 32'(diff), 32'd0);
            check("midrst_done", 32'(done), 32'd0);
            check("midrst_borrow", 32'(borrow_out), 32'd0);
            pulses = 0;
            for (int n = 0; n < 8; n++) begin
                tick();
                if (done) pulses++;
            end
            check("midrst_no_done", 32'(pulses), 32'd0);

            do_op(16'h0012, 16'h0345, lat, pulses);
            check("post_rst_latency", 32'(lat), 32'(L_NEG));
            check("post_rst_pulses", 32'(pulses), 32'd1);
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
            check("post_rst_diff", 32'(diff), 32'h0333);
`else
            check("post_rst_diff", 32'(diff), 32'h9667);
`endif
            check("post_rst_borrow", 32'(borrow_out), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_serial_subtractor.md
Name: bcd_serial_subtractor

Overview:
- Multi-digit BCD subtractor computing diff = a - b.
- Digit-serial: one BCD digit per clock, LSB digit first, with a ripple borrow held in a register.
- This is the subtraction counterpart of the team's BCD digit adder. It serves counter/calculator datapaths that need decimal decrement and difference without a binary round-trip.
- Start/ready/done handshake, so an upstream controller can issue operations back to back.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- a  input  4*DIGITS  minuend; packed BCD, digit 0 in bits [3:0]; sampled on the accepted start.
- b  input  4*DIGITS  subtrahend; same format and sampling as a.
- ready  output  1  high in IDLE; block can accept start.
- done  output  1  one-cycle pulse; result valid.
- diff  output  4*DIGITS  packed BCD result; held until the next accepted start.
- borrow_out  output  1  1 = result negative (a < b); held with diff.
- invalid  output  1  1 = some input nibble was > 9; held with diff.

Behaviour:
- Clock and reset: single clock `clock`; `reset` is synchronous, active-high. On reset the FSM goes to IDLE, all registers clear to 0, and ready=1 on the cycle after reset is sampled.
- Reset mid-operation: the operation is abandoned, done does not pulse, and outputs clear.
- FSM states: IDLE, RUN, (NEGATE, feature only), DONE.
- IDLE:
  - ready=1.
  - On start=1: capture a and b, clear the digit index and borrow, compute the invalid flag from every nibble of a and b, then go to RUN.
- RUN:
  - ready=0.
  - Each cycle processes digit i: t = a_i - b_i - borrow (5-bit signed).
  - If t < 0: digit = t + 10 and borrow = 1; otherwise digit = t and borrow = 0.
  - Write the digit into diff[i]; i++.
  - After digit DIGITS-1: borrow_out = final borrow; go to DONE (or NEGATE, see feature).
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge 0 → done high in the cycle after edge DIGITS+1 (DIGITS RUN cycles plus 1 DONE cycle).
- Throughput: the next start can be accepted in the cycle following done.
- start while ready=0 is ignored; there is no queuing.
- Invalid input: invalid=1, diff forced to 0, borrow_out=0, but latency is unchanged.
- Negative result (default build): diff is the ten's complement, i.e. a - b + 10^DIGITS, and borrow_out=1.
- Edge cases:
  - a == b gives diff=0, borrow_out=0.
  - DIGITS=1 is legal.
- Output stability: diff, borrow_out and invalid are stable from done until the next accepted start. diff updates digit by digit during RUN; it is valid only at or after done.

Optional Feature:
- Macro: BCD_SUB_SIGN_MAGNITUDE_EN.
- Defined:
  - If the final borrow is 1 and invalid=0, the FSM enters NEGATE for DIGITS cycles.
  - Each NEGATE cycle computes 0 - diff_i - borrow per digit, through the same digit logic, starting with borrow=0.
  - diff becomes |a - b| and borrow_out=1 remains as the sign.
  - Negative-result latency is 2*DIGITS+1; positive-result latency is unchanged.
- Undefined: NEGATE state is absent; the ten's-complement result is output.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W = 4, BCD_MAX = 9, BCD_RADIX = 10.
  - FSM state encoding for IDLE/RUN/NEGATE/DONE.
  - Function is_bcd_digit.
- Sub-module bcd_digit_subtractor: combinational; inputs x[3:0], y[3:0], bin; outputs d[3:0], bout. Instantiated once and reused by both RUN and NEGATE.

Test Plan:
- DIGITS=4, a=0x5000, b=0x1234, start → done in the cycle after edge 5; diff=0x3766, borrow_out=0, invalid=0.
- a=0x0100, b=0x0001 → diff=0x0099, borrow_out=0 (borrow ripples through two digits).
- a=0x0012, b=0x0345:
  - Default build → diff=0x9667, borrow_out=1, done after edge 5.
  - With BCD_SUB_SIGN_MAGNITUDE_EN → diff=0x0333, borrow_out=1, done after edge 9.
- a=0x00A0, b=0x0001 → invalid=1, diff=0x0000, borrow_out=0, same latency; a=0x9999, b=0x9999 → diff=0, borrow_out=0.
- Pulse start again while in RUN → ignored; first result is unchanged and done pulses only once.
- reset=1 during RUN digit 2 → ready=1, diff=0, done=0 the cycle after reset; a fresh start then completes normally.
